nonce_uart_tx: RTL and testbench

- Downstream of the miner and processor. When the processor raises its send request, this block latches the winning 32-bit nonce.
- It serialises the nonce over a UART 8N1 line to the host PC as a 5-byte frame: a sync byte, then the nonce bytes MSB-first.
- The block runs on the 100 MHz board clock alongside the miner control and the seven-segment driver.

---
 rtl/nonce_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_nonce_uart_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_uart_tx.sv
// Serialises a latched 32-bit nonce as a 5-byte UART 8N1 frame: SYNC_BYTE, then nonce MSB-first.
// Latency: tx drops for the start bit 1 cycle after send is accepted; done pulses 50*CLKS_PER_BIT cycles after that.
// Backpressure: send is only accepted while idle (busy=0); requests during a frame are dropped, not queued.
module nonce_uart_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'h4E
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] nonce,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // Counter just wide enough for 0..CLKS_PER_BIT-1; guard keeps a legal width for tiny values.
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] baudCnt;
    logic [CW-1:0] baudNext;
    logic [2:0]    bitIdx;
    logic [2:0]    bitNext;
    logic [2:0]    byteIdx;
    logic [2:0]    byteNext;
    // Whole frame is latched at acceptance; the byte on the wire is always the top 8 bits,
    // and the register shifts left by a byte after each stop bit.
    logic [39:0]   frameReg;
    logic [39:0]   frameNext;
    logic          txReg;
    logic          txNext;
    logic          busyReg;
    logic          busyNext;
    logic          doneReg;
    logic          doneNext;

    logic          baudLast;
    logic [7:0]    curByte;
    logic [2:0]    bitIdxInc;

    assign baudLast  = (baudCnt == BAUD_LAST);
    assign curByte   = frameReg[39:32];
    assign bitIdxInc = bitIdx + 3'd1;

    assign tx   = txReg;
    assign busy = busyReg;
    assign done = doneReg;

    // State and registered outputs; reset abandons any partial frame with the line high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            frameReg <= '0;
            txReg    <= 1'b1;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            byteIdx  <= byteNext;
            frameReg <= frameNext;
            txReg    <= txNext;
            busyReg  <= busyNext;
            doneReg  <= doneNext;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so tx/busy/done come straight from flops.
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        byteNext  = byteIdx;
        frameNext = frameReg;
        txNext    = 1'b1;
        busyNext  = 1'b1;
        doneNext  = 1'b0;

        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (send) begin
                    stateNext = START;
                    frameNext = {SYNC_BYTE, nonce};
                    byteNext  = 3'd0;
                    bitNext   = 3'd0;
                    baudNext  = '0;
                    txNext    = 1'b0;
                    busyNext  = 1'b1;
                end
            end

            START: begin
                if (baudLast) begin
                    stateNext = DATA;
                    baudNext  = '0;
                    bitNext   = 3'd0;
                    txNext    = curByte[0];
                end else begin
                    baudNext  = baudCnt + CW'(1);
                    txNext    = 1'b0;
                end
            end

            DATA: begin
                if (baudLast) begin
                    baudNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                        txNext    = 1'b1;
                    end else begin
                        bitNext   = bitIdxInc;
                        txNext    = curByte[bitIdxInc];
                    end
                end else begin
                    baudNext = baudCnt + CW'(1);
                    txNext   = curByte[bitIdx];
                end
            end

            STOP: begin
                if (baudLast) begin
                    baudNext = '0;
                    if (byteIdx == 3'd4) begin
                        // Last stop bit ends: done and busy-low land on the same cycle, line stays high.
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                        doneNext  = 1'b1;
                    end else begin
                        // Straight into the next start bit, no inter-byte idle.
                        stateNext = START;
                        byteNext  = byteIdx + 3'd1;
                        frameNext = {frameReg[31:0], 8'h00};
                        txNext    = 1'b0;
                    end
                end else begin
                    baudNext = baudCnt + CW'(1);
                end
            end

            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nonce_uart_tx.sv
module tb_nonce_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 50 * CPB;

    logic        clock;
    logic        reset;
    logic        send;
    logic [31:0] nonce;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    nonce_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'h4E)
    ) dut (
        .clock(clock),
        .reset(reset),
        .send (send),
        .nonce(nonce),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model: expected line level per cycle ----------------
    int   cyc = 0;
    int   mPos = -1;          // cycle offset into the current frame, -1 when idle
    logic mBits [50];         // 50 bit-times of the frame (start, 8 data LSB-first, stop) x5
    logic expDone = 1'b0;
    logic modelValid = 1'b0;

    always @(posedge clock) begin
        logic [39:0] f;
        logic [7:0]  b;
        cyc++;
        expDone = 1'b0;
        if (reset) begin
            mPos = -1;
            modelValid = 1'b1;
        end else if (mPos < 0) begin
            if (send === 1'b1) begin
                f = {8'h4E, nonce};
                for (int k = 0; k < 5; k++) begin
                    b = f[39 - 8*k -: 8];
                    mBits[10*k] = 1'b0;
                    for (int i = 0; i < 8; i++) mBits[10*k + 1 + i] = b[i];
                    mBits[10*k + 9] = 1'b1;
                end
                mPos = 0;
            end
        end else begin
            mPos++;
            if (mPos == FRAME_CYC) begin
                mPos = -1;
                expDone = 1'b1;
            end
        end
    end

    // ---------------- observers: compare, UART decoder, done/edge timing ----------------
    logic [7:0] rxQ[$];
    int         startQ[$];
    int         doneQ[$];
    logic       rxActive = 1'b0;
    int         rxCnt = 0;
    logic [7:0] rxByte = 8'h00;
    logic       prevTx = 1'b1;
    logic       edgeEn = 1'b0;
    int         lastEdge = -1;
    int         nInt = 0;
    int         badInt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic eTx;
        logic eBusy;
        if (modelValid) begin
            eTx   = (mPos >= 0) ? mBits[mPos / CPB] : 1'b1;
            eBusy = (mPos >= 0);
            checks++;
            if ({tx, busy, done} !== {eTx, eBusy, expDone}) begin
                errors++;
                if (errors < 30)
                    $display("FAIL cycle %0d tx/busy/done: got %b%b%b, expected %b%b%b",
                             cyc, tx, busy, done, eTx, eBusy, expDone);
            end
        end
        if (done === 1'b1) doneQ.push_back(cyc);
        if (edgeEn) begin
            if (busy === 1'b1 && tx !== prevTx) begin
                if (lastEdge >= 0) begin
                    nInt++;
                    if ((cyc - lastEdge) % CPB != 0) badInt++;
                end
                lastEdge = cyc;
            end
            if (busy !== 1'b1) lastEdge = -1;
        end
        if (reset === 1'b1) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (prevTx === 1'b1 && tx === 1'b0) begin
                rxActive = 1'b1;
                rxCnt = 0;
                startQ.push_back(cyc);
            end
        end else begin
            rxCnt++;
            if (rxCnt >= CPB + CPB/2 && rxCnt <= 8*CPB + CPB/2 && (rxCnt - CPB/2) % CPB == 0)
                rxByte = {tx, rxByte[7:1]};
            if (rxCnt == 9*CPB + CPB/2) begin
                check("stop bit level", {31'd0, tx}, 32'd1);
                rxQ.push_back(rxByte);
                rxActive = 1'b0;
            end
        end
        prevTx = tx;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulseSend(input logic [31:0] n, output int sc);
        @(posedge clock); #1;
        send = 1'b1;
        nonce = n;
        sc = cyc;
        @(posedge clock); #1;
        send = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitDones(input int target, input int maxCyc);
        int t = 0;
        while (doneQ.size() < target && t < maxCyc) begin
            @(negedge clock); #1;
            t++;
        end
        if (doneQ.size() < target) check("done timeout", doneQ.size(), target);
    endtask

    task automatic waitStart(input int maxCyc);
        int t = 0;
        while (startQ.size() < 1 && t < maxCyc) begin
            @(negedge clock); #1;
            t++;
        end
        if (startQ.size() < 1) check("start bit timeout", 0, 1);
    endtask

    task automatic checkFrame(input string name, input int base, input logic [31:0] n);
        logic [39:0] f;
        f = {8'h4E, n};
        for (int k = 0; k < 5; k++) begin
            if (rxQ.size() > base + k) check(name, rxQ[base + k], f[39 - 8*k -: 8]);
            else check({name, " missing byte"}, rxQ.size(), base + k + 1);
        end
    endtask

    task automatic clearObs();
        rxQ.delete();
        startQ.delete();
        doneQ.delete();
    endtask

    initial begin
        int sc;
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        reset = 1'b1;
        send  = 1'b0;
        nonce = 32'h0;
        idle(2);
        reset = 1'b0;
        @(negedge clock);
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);

        // Idle 100 cycles: nothing on the line.
        clearObs();
        idle(100);
        check("idle no done", doneQ.size(), 0);
        check("idle no start", startQ.size(), 0);

        // Single frame with a mid-frame request that must be ignored.
        clearObs();
        edgeEn = 1'b1;
        pulseSend(32'h42A14695, sc);
        waitStart(10);
        if (startQ.size() > 0) begin
            check("send-to-start latency", startQ[0] - sc, 1);
            while (cyc < startQ[0] + 50) begin
                @(negedge clock); #1;
            end
            send  = 1'b1;
            nonce = 32'hDEADBEEF;
            @(posedge clock); #1;
            send  = 1'b0;
        end
        waitDones(1, 300);
        idle(60);
        edgeEn = 1'b0;
        check("frame1 byte count", rxQ.size(), 5);
        check("frame1 byte0", (rxQ.size() > 0) ? rxQ[0] : 8'hxx, 8'h4E);
        check("frame1 byte1", (rxQ.size() > 1) ? rxQ[1] : 8'hxx, 8'h42);
        check("frame1 byte2", (rxQ.size() > 2) ? rxQ[2] : 8'hxx, 8'hA1);
        check("frame1 byte3", (rxQ.size() > 3) ? rxQ[3] : 8'hxx, 8'h46);
        check("frame1 byte4", (rxQ.size() > 4) ? rxQ[4] : 8'hxx, 8'h95);
        check("frame1 done count", doneQ.size(), 1);
        if (doneQ.size() > 0 && startQ.size() > 0)
            check("start-to-done cycles", doneQ[0] - startQ[0], 200);
        if (startQ.size() == 5 && doneQ.size() > 0) begin
            for (int k = 0; k < 4; k++) check("byte period", startQ[k+1] - startQ[k], 40);
            check("last byte period", doneQ[0] - startQ[4], 40);
        end else begin
            check("frame1 start count", startQ.size(), 5);
        end
        check("edge intervals off-grid", badInt, 0);
        check("edge intervals seen", (nInt > 10) ? 1 : 0, 1);

        // send held high: three back-to-back frames, then release on the third done cycle.
        clearObs();
        @(posedge clock); #1;
        send  = 1'b1;
        nonce = 32'h00000001;
        waitDones(3, 800);
        send = 1'b0;
        idle(30);
        check("hold done count", doneQ.size(), 3);
        check("hold start count", startQ.size(), 15);
        for (int fr = 0; fr < 3; fr++) checkFrame("hold frame byte", 5*fr, 32'h00000001);
        if (doneQ.size() == 3 && startQ.size() == 15) begin
            check("gap frame1-2", startQ[5] - doneQ[0], 1);
            check("gap frame2-3", startQ[10] - doneQ[1], 1);
        end

        // Reset at cycle 90 of a frame: abandon without done, then a clean frame.
        clearObs();
        pulseSend(32'h12345678, sc);
        waitStart(10);
        if (startQ.size() > 0) begin
            while (cyc < startQ[0] + 90) begin
                @(negedge clock); #1;
            end
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("post-reset tx", {31'd0, tx}, 32'd1);
        check("post-reset busy", {31'd0, busy}, 32'd0);
        idle(30);
        check("aborted frame no done", doneQ.size(), 0);
        clearObs();
        pulseSend(32'hC0FFEE11, sc);
        waitDones(1, 300);
        idle(10);
        check("after-reset byte count", rxQ.size(), 5);
        checkFrame("after-reset frame byte", 0, 32'hC0FFEE11);
        if (doneQ.size() > 0 && startQ.size() > 0)
            check("after-reset start-to-done", doneQ[0] - startQ[0], 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
